data_writeback_cache_controller: RTL and testbench

Miss-handling controller sitting directly upstream of the write-back data cache ways: it decides, per CPU access, whether the way is written directly (store hit), or whether the pipeline must stall while a dirty victim block is written back and the missing block is filled from memory. It sequences word-by-word bus transfers, drives the way's write enable, address, dirty-in and write-data select, and releases the stall once the refilled block hits.

---
 rtl/data_writeback_cache_controller_pkg.sv | 19 +
 rtl/data_writeback_cache_controller_block_word_counter.sv | 38 +++
 rtl/data_writeback_cache_controller.sv | 117 +++++++++++
 tb/tb_data_writeback_cache_controller.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_writeback_cache_controller_pkg.sv
// Shared types and sizing helpers for the write-back data cache miss controller.
package data_cache_pkg;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } cache_state_t;

    localparam int BLOCKWORDS      = 4;
    localparam int DEFAULT_TAGBITS = 14;
    localparam int DEFAULT_SETBITS = 32 - DEFAULT_TAGBITS - 4;

    // Set field sits between the tag and the 4 block-offset bits.
    function automatic int set_width(input int tagbits);
        return 32 - tagbits - 4;
    endfunction

endpackage

// File: rtl/data_writeback_cache_controller_block_word_counter.sv
// Word index within the block being written back or filled; advances once per accepted bus beat.
module block_word_counter
    import data_cache_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             last
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = &cnt_q;

endmodule

// File: rtl/data_writeback_cache_controller.sv
// Miss controller for a write-back data cache: store hits write the way directly, misses
// stall the pipeline while a dirty victim is written back and the block is refilled.
module data_writeback_cache_controller
    import data_cache_pkg::*;
#(
    parameter int tagbits   = DEFAULT_TAGBITS,
    parameter int blocksize = BLOCKWORDS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               MemRE,
    input  logic               MemWE,
    input  logic [31:0]        ANew,
    input  logic               Hit,
    input  logic               Dirty,
    input  logic [tagbits-1:0] VictimTag,
    input  logic               BusReady,
    output logic               Stall,
    output logic               CWE,
    output logic               DirtyIn,
    output logic [31:0]        CacheA,
    output logic               UseBusData,
    output logic               BusRE,
    output logic               BusWE,
    output logic [31:0]        BusA
);

    localparam int CNTW = $clog2(blocksize);
    localparam int SETW = set_width(tagbits);

    cache_state_t    state_q;
    cache_state_t    state_d;
    logic [CNTW-1:0] cnt;
    logic            cnt_last;
    logic            cnt_en;
    logic            cnt_clr;
    logic            request;
    logic [31:0]     block_addr;
    logic [31:0]     victim_addr;

    assign request     = MemRE | MemWE;
    assign block_addr  = {ANew[31:CNTW+2], cnt, 2'b00};
    assign victim_addr = {VictimTag, ANew[31-tagbits -: SETW], cnt, 2'b00};
    // The counter only moves while a block transfer is in flight; READY keeps it parked at word 0.
    assign cnt_en      = BusReady & (state_q != READY);
    assign cnt_clr     = (state_q == READY);

    block_word_counter #(
        .WIDTH (CNTW)
    ) u_word_counter (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= READY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        Stall      = 1'b0;
        CWE        = 1'b0;
        DirtyIn    = 1'b0;
        CacheA     = ANew;
        UseBusData = 1'b0;
        BusRE      = 1'b0;
        BusWE      = 1'b0;
        BusA       = block_addr;
        unique case (state_q)
            READY: begin
                // A simultaneous load and store request is handled as a store.
                if (request) begin
                    if (Hit) begin
                        if (MemWE) begin
                            CWE     = 1'b1;
                            DirtyIn = 1'b1;
                        end
                    end else begin
                        Stall   = 1'b1;
                        state_d = Dirty ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                Stall  = 1'b1;
                BusWE  = 1'b1;
                BusA   = victim_addr;
                CacheA = block_addr;
                if (BusReady && cnt_last) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                Stall      = 1'b1;
                BusRE      = 1'b1;
                UseBusData = 1'b1;
                CWE        = BusReady;
                CacheA     = block_addr;
                if (BusReady && cnt_last) begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

endmodule

// File: tb/tb_data_writeback_cache_controller.sv
// Scoreboard bench for the write-back cache miss controller: expected bus beats are queued
// with the stimulus and matched against the beats the controller actually issues.
module tb_data_writeback_cache_controller;

    localparam int TAGBITS = 14;

    logic               clk = 1'b0;
    logic               reset;
    logic               MemRE;
    logic               MemWE;
    logic [31:0]        ANew;
    logic               Hit;
    logic               Dirty;
    logic [TAGBITS-1:0] VictimTag;
    logic               BusReady;
    logic               Stall;
    logic               CWE;
    logic               DirtyIn;
    logic [31:0]        CacheA;
    logic               UseBusData;
    logic               BusRE;
    logic               BusWE;
    logic [31:0]        BusA;

    logic hit_base;
    logic fill_done;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic        cwe;
        logic        din;
        logic        ubd;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    data_writeback_cache_controller #(
        .tagbits   (TAGBITS),
        .blocksize (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRE      (MemRE),
        .MemWE      (MemWE),
        .ANew       (ANew),
        .Hit        (Hit),
        .Dirty      (Dirty),
        .VictimTag  (VictimTag),
        .BusReady   (BusReady),
        .Stall      (Stall),
        .CWE        (CWE),
        .DirtyIn    (DirtyIn),
        .CacheA     (CacheA),
        .UseBusData (UseBusData),
        .BusRE      (BusRE),
        .BusWE      (BusWE),
        .BusA       (BusA)
    );

    always #5 clk = ~clk;

    // Stand-in for the way's tag compare: the block becomes a hit once its last word is refilled.
    always @(posedge clk) begin
        if (reset || !Stall) begin
            fill_done <= 1'b0;
        end else if (CWE && UseBusData && CacheA[3:2] == 2'b11) begin
            fill_done <= 1'b1;
        end
    end

    assign Hit = hit_base | fill_done;

    function automatic beat_t make_beat(input logic we, input logic [31:0] addr);
        beat_t b;
        b.we   = we;
        b.addr = addr;
        b.cwe  = ~we;
        b.din  = 1'b0;
        b.ubd  = ~we;
        return b;
    endfunction

    task automatic push_fill(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(make_beat(1'b0, (a & 32'hFFFF_FFF0) | (32'(i) << 2)));
        end
    endtask

    task automatic push_writeback(input logic [TAGBITS-1:0] vt, input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(make_beat(1'b1,
                (32'(vt) << (32 - TAGBITS)) | (a & 32'h0003_FFF0) | (32'(i) << 2)));
        end
    endtask

    // Runs one miss to completion, recording every accepted beat; stops in the first unstalled cycle.
    task automatic drive_miss(input int max_cycles, input bit toggle_ready, input bit drop_after_first,
                              output int stall_cycles, output bit completed, output int hold_errs);
        int          nbeats = 0;
        bit          holding = 0;
        logic [31:0] held = '0;
        stall_cycles = 0;
        completed    = 0;
        hold_errs    = 0;
        for (int c = 0; c < max_cycles; c++) begin
            BusReady = toggle_ready ? (c % 2 == 1) : 1'b1;
            if (drop_after_first && nbeats == 1) begin
                MemRE = 1'b0;
                MemWE = 1'b0;
            end
            #1;
            if (!Stall) begin
                completed = 1;
                break;
            end
            stall_cycles++;
            if (BusRE || BusWE) begin
                if (holding && BusA !== held) hold_errs++;
                if (BusReady) begin
                    obs_q.push_back('{BusWE, BusA, CWE, DirtyIn, UseBusData});
                    nbeats++;
                    holding = 0;
                end else begin
                    if (CWE !== 1'b0) hold_errs++;
                    held    = BusA;
                    holding = 1;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic compare_beats(input string name);
        beat_t e;
        beat_t o;
        tests_run++;
        if (obs_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("[TB] FAIL %s_beat_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if ({o.we, o.addr, o.cwe, o.din, o.ubd} !== {e.we, e.addr, e.cwe, e.din, e.ubd}) begin
                tests_failed++;
                $display("[TB] FAIL %s_beat: got we=%b a=%h cwe=%b din=%b ubd=%b want we=%b a=%h cwe=%b din=%b ubd=%b",
                         name, o.we, o.addr, o.cwe, o.din, o.ubd, e.we, e.addr, e.cwe, e.din, e.ubd);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic check_miss_end(input string name, input bit completed, input int stall_cycles,
                                  input int want_stall, input int hold_errs, input logic [5:0] want_flags);
        tests_run++;
        if (!completed) begin
            tests_failed++;
            $display("[TB] FAIL %s_timeout: got no unstalled cycle want completion", name);
        end
        tests_run++;
        if (stall_cycles !== want_stall) begin
            tests_failed++;
            $display("[TB] FAIL %s_stall_cycles: got %0d want %0d", name, stall_cycles, want_stall);
        end
        tests_run++;
        if (hold_errs !== 0) begin
            tests_failed++;
            $display("[TB] FAIL %s_hold: got %0d unstable low-ready cycles want 0", name, hold_errs);
        end
        tests_run++;
        if ({Stall, CWE, DirtyIn, UseBusData, BusRE, BusWE} !== want_flags) begin
            tests_failed++;
            $display("[TB] FAIL %s_final: got %b want %b", name,
                     {Stall, CWE, DirtyIn, UseBusData, BusRE, BusWE}, want_flags);
        end
    endtask

    task automatic idle_inputs();
        MemRE = 1'b0; MemWE = 1'b0; hit_base = 1'b0; Dirty = 1'b0; BusReady = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        ANew = 32'h0000_ABC0;
        VictimTag = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if ({Stall, CWE, BusRE, BusWE} !== 4'b0000 || CacheA !== 32'h0000_ABC0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: got %b a=%h want 0000 a=0000abc0",
                     {Stall, CWE, BusRE, BusWE}, CacheA);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; MemWE = 1'b1; hit_base = 1'b1;
        #1;
        tests_run++;
        if ({Stall, CWE, BusRE, BusWE} !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL reset_hit_store: got %b want 0100", {Stall, CWE, BusRE, BusWE});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_hits();
        ANew = 32'h0000_1008; MemWE = 1'b1; hit_base = 1'b1;
        #1;
        tests_run++;
        if ({Stall, CWE, DirtyIn, UseBusData, BusRE, BusWE} !== 6'b011000 || CacheA !== 32'h0000_1008) begin
            tests_failed++;
            $display("[TB] FAIL store_hit: got %b a=%h want 011000 a=00001008",
                     {Stall, CWE, DirtyIn, UseBusData, BusRE, BusWE}, CacheA);
        end
        @(negedge clk);
        MemWE = 1'b0; MemRE = 1'b1; ANew = 32'h0000_1F04;
        #1;
        tests_run++;
        if ({Stall, CWE, BusRE, BusWE} !== 4'b0000 || CacheA !== 32'h0000_1F04) begin
            tests_failed++;
            $display("[TB] FAIL load_hit: got %b a=%h want 0000 a=00001f04", {Stall, CWE, BusRE, BusWE}, CacheA);
        end
        @(negedge clk);
        MemWE = 1'b1;
        #1;
        tests_run++;
        if ({Stall, CWE, DirtyIn} !== 3'b011) begin
            tests_failed++;
            $display("[TB] FAIL both_req_store: got %b want 011", {Stall, CWE, DirtyIn});
        end
        @(negedge clk);
        MemRE = 1'b0; MemWE = 1'b0; hit_base = 1'b0; Dirty = 1'b1;
        #1;
        tests_run++;
        if ({Stall, CWE, BusRE, BusWE} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL no_request: got %b want 0000", {Stall, CWE, BusRE, BusWE});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_clean_miss();
        int sc; bit done; int he;
        ANew = 32'h0000_2004; MemRE = 1'b1;
        push_fill(ANew);
        drive_miss(40, 1'b0, 1'b0, sc, done, he);
        check_miss_end("clean_miss", done, sc, 5, he, 6'b000000);
        compare_beats("clean_miss");
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_dirty_miss();
        int sc; bit done; int he;
        ANew = 32'h0000_3010; MemWE = 1'b1; Dirty = 1'b1; VictimTag = 14'h0005;
        push_writeback(VictimTag, ANew);
        push_fill(ANew);
        drive_miss(40, 1'b0, 1'b0, sc, done, he);
        check_miss_end("dirty_miss", done, sc, 9, he, 6'b011000);
        tests_run++;
        if (CacheA !== 32'h0000_3010) begin
            tests_failed++;
            $display("[TB] FAIL dirty_miss_store_addr: got %h want 00003010", CacheA);
        end
        compare_beats("dirty_miss");
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_ready_toggle();
        int sc; bit done; int he;
        ANew = 32'h0000_4008; MemRE = 1'b1;
        push_fill(ANew);
        drive_miss(40, 1'b1, 1'b0, sc, done, he);
        check_miss_end("ready_toggle", done, sc, 8, he, 6'b000000);
        compare_beats("ready_toggle");
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid_writeback();
        int sc; bit done; int he;
        ANew = 32'h0000_5000; MemWE = 1'b1; Dirty = 1'b1; VictimTag = 14'h0007; BusReady = 1'b1;
        #1;
        tests_run++;
        if ({Stall, BusWE} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL rst_wb_detect: got %b want 10", {Stall, BusWE});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if (BusWE !== 1'b1 || BusA !== 32'h001C_5004) begin
            tests_failed++;
            $display("[TB] FAIL rst_wb_second_beat: got we=%b a=%h want we=1 a=001c5004", BusWE, BusA);
        end
        @(negedge clk);
        reset = 1'b0; MemWE = 1'b0; Dirty = 1'b0;
        #1;
        tests_run++;
        if ({Stall, CWE, BusRE, BusWE} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL rst_wb_after: got %b want 0000", {Stall, CWE, BusRE, BusWE});
        end
        @(negedge clk);
        ANew = 32'h0000_6004; MemRE = 1'b1;
        push_fill(ANew);
        drive_miss(40, 1'b0, 1'b0, sc, done, he);
        check_miss_end("restart_miss", done, sc, 5, he, 6'b000000);
        compare_beats("restart_miss");
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_request_drop();
        int sc; bit done; int he;
        ANew = 32'h0000_7000; MemRE = 1'b1;
        push_fill(ANew);
        drive_miss(40, 1'b0, 1'b1, sc, done, he);
        check_miss_end("request_drop", done, sc, 5, he, 6'b000000);
        compare_beats("request_drop");
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_hits();
        test_clean_miss();
        test_dirty_miss();
        test_ready_toggle();
        test_reset_mid_writeback();
        test_request_drop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
